alu_seq: RTL and testbench

Parametrised, clocked successor to the combinational ALU.
- Registers the result and a persistent status register (Z, N, C, V, H; S derived).
- Adds a valid/ready handshake and iterative multi-cycle SL/SR/ASR/MUL.
- Sits between the register-file read stage and writeback/PC mux. Branch ops evaluate the registered Z flag.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_iter_unit.sv | 98 +++++++++
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and
// status-register bit positions.
package alu_pkg;

    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_LD  = 5'h01;
    localparam logic [OPW-1:0] OP_ST  = 5'h02;
    localparam logic [OPW-1:0] OP_ADD = 5'h03;
    localparam logic [OPW-1:0] OP_SUB = 5'h04;
    localparam logic [OPW-1:0] OP_AND = 5'h05;
    localparam logic [OPW-1:0] OP_OR  = 5'h06;
    localparam logic [OPW-1:0] OP_XOR = 5'h07;
    localparam logic [OPW-1:0] OP_NOT = 5'h08;
    localparam logic [OPW-1:0] OP_SL  = 5'h09;
    localparam logic [OPW-1:0] OP_SR  = 5'h0A;
    localparam logic [OPW-1:0] OP_ASR = 5'h0B;
    localparam logic [OPW-1:0] OP_MUL = 5'h0C;
    localparam logic [OPW-1:0] OP_BZ  = 5'h10;
    localparam logic [OPW-1:0] OP_BNZ = 5'h11;
    localparam logic [OPW-1:0] OP_BRA = 5'h12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit positions inside the status register
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_H = 4;
    localparam int unsigned NFLAGS = 5;

    function automatic logic is_shift(input logic [OPW-1:0] op);
        return (op == OP_SL) || (op == OP_SR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for SL/SR/ASR (one bit per cycle) and MUL (shift-add,
// WIDTH steps).
// Ports: clk, rst (sync, active-high), start (load operands), op, a, b;
//        done (current cycle performs the final step), result / carry_out /
//        half_bit (values produced by the current step, valid with done).
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HALF  = WIDTH / 2,
    parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             half_bit
);

    localparam logic [WIDTH-1:0] WMAX     = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(WIDTH);

    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] val;      // shift value, or multiplier/low product for MUL
    logic [WIDTH-1:0] hi;       // high product half for MUL
    logic [WIDTH-1:0] mcand;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] val_n;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH:0]   sum;

    // One iteration step
    always_comb begin
        val_n     = val;
        hi_n      = hi;
        sum       = '0;
        carry_out = 1'b0;
        half_bit  = 1'b0;
        case (op_q)
            OP_SL: begin
                val_n     = {val[WIDTH-2:0], 1'b0};
                carry_out = val[WIDTH-1];
                half_bit  = val[HALF-1];
            end
            OP_SR: begin
                val_n     = {1'b0, val[WIDTH-1:1]};
                carry_out = val[0];
                half_bit  = val[HALF];
            end
            OP_ASR: begin
                val_n     = {val[WIDTH-1], val[WIDTH-1:1]};
                carry_out = val[0];
                half_bit  = val[HALF];
            end
            OP_MUL: begin
                // Add multiplicand into the high half, then shift {sum, lo} right
                sum       = {1'b0, hi} + (val[0] ? {1'b0, mcand} : '0);
                hi_n      = sum[WIDTH:1];
                val_n     = {sum[0], val[WIDTH-1:1]};
                carry_out = (hi_n != '0);
            end
            default: ;
        endcase
        result = val_n;
        done   = (cnt == CNTW'(1));
    end

    // Operand latch and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            val   <= '0;
            hi    <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (start) begin
            op_q  <= op;
            val   <= (op == OP_MUL) ? b : a;
            hi    <= '0;
            mcand <= a;
            if (op == OP_MUL || b >= WMAX) begin
                cnt <= CNT_FULL;
            end else begin
                cnt <= CNTW'(b);
            end
        end else if (cnt != '0) begin
            val <= val_n;
            hi  <= hi_n;
            cnt <= cnt - CNTW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshake, persistent status register and
// iterative shifts/multiply.
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake;
//        op, a, b operands; out_valid pulse with out, branch and flags;
//        busy during iterative ops; z/n/c/v/h flags registered, sflag = n^v.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HALF  = WIDTH / 2,
    parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             branch,
    output logic             busy,
    output logic             zflag,
    output logic             nflag,
    output logic             cflag,
    output logic             vflag,
    output logic             hflag,
    output logic             sflag
);

    state_t             state;
    logic [NFLAGS-1:0]  flags;

    logic               accept;
    logic               iter_c;
    logic               it_start;
    logic               it_done;
    logic [WIDTH-1:0]   it_result;
    logic               it_carry;
    logic               it_half;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   diff_c;
    logic [WIDTH-1:0]   res_c;
    logic               c_c;
    logic               h_c;
    logic               v_c;
    logic               wr_c;
    logic               br_c;

    assign accept   = in_valid && in_ready;
    assign iter_c   = (op == OP_MUL) || (is_shift(op) && (b != '0));
    assign it_start = accept && iter_c;

    assign zflag = flags[FLAG_Z];
    assign nflag = flags[FLAG_N];
    assign cflag = flags[FLAG_C];
    assign vflag = flags[FLAG_V];
    assign hflag = flags[FLAG_H];
    assign sflag = flags[FLAG_N] ^ flags[FLAG_V];

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .HALF  (HALF),
        .CNTW  (CNTW)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (it_start),
        .op        (op),
        .a         (a),
        .b         (b),
        .done      (it_done),
        .result    (it_result),
        .carry_out (it_carry),
        .half_bit  (it_half)
    );

    // Single-cycle result and flag candidates
    always_comb begin
        sum_c  = {1'b0, a} + {1'b0, b};
        diff_c = a - b;
        res_c  = '0;
        c_c    = 1'b0;
        h_c    = 1'b0;
        v_c    = 1'b0;
        wr_c   = 1'b0;
        br_c   = 1'b0;
        case (op)
            OP_LD: res_c = b;
            OP_ST: res_c = a;
            OP_ADD: begin
                res_c = sum_c[WIDTH-1:0];
                c_c   = sum_c[WIDTH];
                // Carry into bit HALF recovered from the sum bit
                h_c   = a[HALF] ^ b[HALF] ^ sum_c[HALF];
                v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
                wr_c  = 1'b1;
            end
            OP_SUB: begin
                res_c = diff_c;
                c_c   = (a < b);
                // Borrow into bit HALF recovered from the difference bit
                h_c   = a[HALF] ^ b[HALF] ^ diff_c[HALF];
                v_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
                wr_c  = 1'b1;
            end
            OP_AND: begin res_c = a & b; wr_c = 1'b1; end
            OP_OR:  begin res_c = a | b; wr_c = 1'b1; end
            OP_XOR: begin res_c = a ^ b; wr_c = 1'b1; end
            OP_NOT: begin res_c = ~a;    wr_c = 1'b1; end
            // Zero-count shifts pass a through and finish in one cycle
            OP_SL, OP_SR, OP_ASR: begin res_c = a; wr_c = 1'b1; end
            OP_BZ:  begin res_c = b; br_c = flags[FLAG_Z];  end
            OP_BNZ: begin res_c = b; br_c = ~flags[FLAG_Z]; end
            OP_BRA: begin res_c = b; br_c = 1'b1;           end
            default: ;
        endcase
    end

    // Control FSM, result and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            branch    <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (iter_c) begin
                            state <= (op == OP_MUL) ? MUL : SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out       <= res_c;
                            branch    <= br_c;
                            if (wr_c) begin
                                flags[FLAG_Z] <= (res_c == '0);
                                flags[FLAG_N] <= res_c[WIDTH-1];
                                flags[FLAG_C] <= c_c;
                                flags[FLAG_V] <= v_c;
                                flags[FLAG_H] <= h_c;
                            end
                        end
                    end
                end
                SHIFT, MUL: begin
                    if (it_done) begin
                        state         <= DONE;
                        busy          <= 1'b0;
                        out_valid     <= 1'b1;
                        out           <= it_result;
                        branch        <= 1'b0;
                        flags[FLAG_Z] <= (it_result == '0);
                        flags[FLAG_N] <= it_result[WIDTH-1];
                        flags[FLAG_C] <= it_carry;
                        flags[FLAG_V] <= 1'b0;
                        flags[FLAG_H] <= it_half;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed scenarios plus
// randomized operations against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] out;
    logic        branch;
    logic        busy;
    logic        zflag, nflag, cflag, vflag, hflag, sflag;

    int total = 0;
    int bad   = 0;

    // Reference status register
    logic mz = 1'b0, mn = 1'b0, mc = 1'b0, mv = 1'b0, mh = 1'b0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out),
        .branch    (branch),
        .busy      (busy),
        .zflag     (zflag),
        .nflag     (nflag),
        .cflag     (cflag),
        .vflag     (vflag),
        .hflag     (hflag),
        .sflag     (sflag)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected result of one operation from the current reference flags
    task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic br, output int lat,
                         output logic wr, output logic c, output logic h, output logic v);
        logic [32:0] s;
        logic [63:0] p;
        logic [31:0] prev;
        int n;
        r = 32'h0; br = 1'b0; lat = 1; wr = 1'b0; c = 1'b0; h = 1'b0; v = 1'b0;
        case (o)
            5'h01: r = y;
            5'h02: r = x;
            5'h03: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[31:0];
                c  = s[32];
                h  = (int'(x[15:0]) + int'(y[15:0])) > 65535;
                v  = (x[31] == y[31]) && (r[31] != x[31]);
                wr = 1'b1;
            end
            5'h04: begin
                r  = x - y;
                c  = x < y;
                h  = x[15:0] < y[15:0];
                v  = (x[31] != y[31]) && (r[31] != x[31]);
                wr = 1'b1;
            end
            5'h05: begin r = x & y; wr = 1'b1; end
            5'h06: begin r = x | y; wr = 1'b1; end
            5'h07: begin r = x ^ y; wr = 1'b1; end
            5'h08: begin r = ~x;    wr = 1'b1; end
            5'h09, 5'h0A, 5'h0B: begin
                wr = 1'b1;
                n  = (y >= 32) ? 32 : int'(y);
                if (n == 0) begin
                    r = x;
                end else begin
                    lat = n + 1;
                    if (o == 5'h09) begin
                        prev = x << (n - 1);
                        r    = x << n;
                        c    = prev[31];
                        h    = prev[15];
                    end else if (o == 5'h0A) begin
                        prev = x >> (n - 1);
                        r    = x >> n;
                        c    = prev[0];
                        h    = prev[16];
                    end else begin
                        prev = $signed(x) >>> (n - 1);
                        r    = $signed(x) >>> n;
                        c    = prev[0];
                        h    = prev[16];
                    end
                end
            end
            5'h0C: begin
                p   = 64'(x) * 64'(y);
                r   = p[31:0];
                c   = (p[63:32] != 0);
                lat = 33;
                wr  = 1'b1;
            end
            5'h10: begin r = y; br = mz;  end
            5'h11: begin r = y; br = !mz; end
            5'h12: begin r = y; br = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] er;
        logic eb, ew, ec, eh, ev;
        int el;
        int lat;
        int waitc;
        model(o, x, y, er, eb, el, ew, ec, eh, ev);
        waitc = 0;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check($sformatf("ready_wait op%0h", o), in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        if (el > 1) begin
            check($sformatf("busy op%0h", o), busy, 1);
            check($sformatf("not_ready op%0h", o), in_ready, 0);
        end
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (ew) begin
            mz = (er == 0); mn = er[31]; mc = ec; mv = ev; mh = eh;
        end
        check($sformatf("latency op%0h", o), lat, el);
        check($sformatf("out op%0h a=%0h b=%0h", o, x, y), out, er);
        check($sformatf("branch op%0h", o), branch, eb);
        check($sformatf("flags zncvhs op%0h a=%0h b=%0h", o, x, y),
              {zflag, nflag, cflag, vflag, hflag, sflag},
              {mz, mn, mc, mv, mh, mn ^ mv});
        @(negedge clk);
        check($sformatf("pulse op%0h", o), out_valid, 0);
    endtask

    initial begin
        logic [4:0] ops [19];
        logic [4:0] o;
        logic [31:0] x, y;
        logic seen;

        ops = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                5'h0B, 5'h0C, 5'h10, 5'h11, 5'h12, 5'h00, 5'h0D, 5'h13, 5'h1F};

        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset ready", in_ready, 1);
        check("reset out", out, 0);
        check("reset flags", {zflag, nflag, cflag, vflag, hflag, sflag}, 0);
        check("reset valid/branch/busy", {out_valid, branch, busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_op(5'h03, 32'hFFFF_FFFF, 32'h1);
        run_op(5'h03, 32'h7FFF_FFFF, 32'h1);
        run_op(5'h04, 32'h0, 32'h1);
        run_op(5'h09, 32'h1, 32'd4);
        run_op(5'h0B, 32'h8000_0000, 32'd40);
        run_op(5'h0C, 32'h0001_0000, 32'h0001_0000);
        run_op(5'h03, 32'h0, 32'h0);
        run_op(5'h10, 32'h0, 32'h40);
        run_op(5'h01, 32'h0, 32'h5);
        run_op(5'h11, 32'h0, 32'h80);
        run_op(5'h0A, 32'h0001_8000, 32'd16);
        run_op(5'h0A, 32'hA5A5_0000, 32'd0);
        run_op(5'h09, 32'hFFFF_FFFF, 32'd32);
        run_op(5'h1F, 32'h1234, 32'h5678);

        // Reset in the middle of a multiply aborts it
        op = 5'h0C; a = 32'h3; b = 32'h5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mz = 0; mn = 0; mc = 0; mv = 0; mh = 0;
        check("abort ready", in_ready, 1);
        check("abort out", out, 0);
        check("abort flags", {zflag, nflag, cflag, vflag, hflag, sflag}, 0);
        check("abort busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= out_valid;
            @(negedge clk);
        end
        check("abort no out_valid", seen, 0);
        run_op(5'h05, 32'hF0F0_1234, 32'h0FF0_FFFF);

        // Randomized operations
        for (int i = 0; i < 300; i++) begin
            o = ops[$urandom_range(0, 18)];
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) y = x;
            if (o == 5'h09 || o == 5'h0A || o == 5'h0B) y = 32'($urandom_range(0, 40));
            run_op(o, x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
